// File: rtl/mem_bus_responder.sv
// Target end of the load/store bus: DEPTH x 64-bit word array with programmable wait states,
// sub-word lane access, and misalignment / out-of-range error reporting.
module mem_bus_responder #(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_d, valid_d, error_d;
  logic [DATA_W-1:0]   rdata_d;

  logic                lat_write_q;
  logic [63:0]         lat_addr_q;
  logic [1:0]          lat_size_q;
  logic [DATA_W-1:0]   lat_wdata_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept_c, commit_c;
  logic                c_write;
  logic [63:0]         c_addr;
  logic [1:0]          c_size;
  logic [DATA_W-1:0]   c_wdata;
  logic                misalign_c, oor_c, err_c, wr_en_c;
  logic [IDX_W-1:0]    idx_c;
  logic [5:0]          shift_c;
  logic [DATA_W-1:0]   mask_c, word_c, load_c, merged_c;

  // A zero-wait request commits on its accept edge, so it must use the live request fields.
  always_comb begin
    c_write = lat_write_q;
    c_addr  = lat_addr_q;
    c_size  = lat_size_q;
    c_wdata = lat_wdata_q;
    if (state_q == IDLE) begin
      c_write = req_write;
      c_addr  = req_addr;
      c_size  = req_size;
      c_wdata = req_wdata;
    end
  end

  // Access decode: alignment, range, lane mask and byte-merge for stores.
  always_comb begin
    misalign_c = 1'b0;
    mask_c     = '1;
    case (c_size)
      2'b00: begin misalign_c = 1'b0;           mask_c = DATA_W'(64'h0000_0000_0000_00FF); end
      2'b01: begin misalign_c = c_addr[0];      mask_c = DATA_W'(64'h0000_0000_0000_FFFF); end
      2'b10: begin misalign_c = |c_addr[1:0];   mask_c = DATA_W'(64'h0000_0000_FFFF_FFFF); end
      default: begin misalign_c = |c_addr[2:0]; mask_c = '1; end
    endcase
    oor_c    = c_addr[63:3] >= 61'(DEPTH);
    err_c    = misalign_c | oor_c;
    idx_c    = c_addr[IDX_W+2:3];
    shift_c  = {c_addr[2:0], 3'b000};
    word_c   = mem[idx_c];
    load_c   = (word_c >> shift_c) & mask_c;
    merged_c = (word_c & ~(mask_c << shift_c)) | ((c_wdata & mask_c) << shift_c);
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = req_ready;
    valid_d  = rsp_valid;
    rdata_d  = rsp_rdata;
    error_d  = rsp_error;
    accept_c = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid && req_ready) begin
          accept_c = 1'b1;
          ready_d  = 1'b0;
          if (WAIT_STATES == 0) begin
            commit_c = 1'b1;
            cnt_d    = '0;
            state_d  = RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_STATES);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          commit_c = 1'b1;
          cnt_d    = '0;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
    if (commit_c) begin
      valid_d = 1'b1;
      error_d = err_c;
      rdata_d = (err_c || c_write) ? '0 : load_c;
    end
  end

  assign wr_en_c = commit_c & c_write & ~err_c;

  // State and output registers; reset wins over any handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= '0;
      lat_size_q  <= '0;
      lat_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_ready <= ready_d;
      rsp_valid <= valid_d;
      rsp_rdata <= rdata_d;
      rsp_error <= error_d;
      if (accept_c) begin
        lat_write_q <= req_write;
        lat_addr_q  <= req_addr;
        lat_size_q  <= req_size;
        lat_wdata_q <= req_wdata;
      end
    end
  end

  // Array contents survive reset; a store aborted by reset never reaches here.
  always_ff @(posedge clock) begin
    if (!reset && wr_en_c) begin
      mem[idx_c] <= merged_c;
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: a 2-wait-state instance for the directed
// scenarios and a zero-wait instance for back-to-back throughput.
module tb_mem_bus_responder;

  localparam int unsigned DEPTH = 4096;
  localparam int unsigned WS    = 2;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_error;
  logic [63:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size;
  logic        z_req_valid, z_req_ready, z_req_write, z_rsp_valid, z_rsp_ready, z_rsp_error;
  logic [63:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [1:0]  z_req_size;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  logic [7:0] mb [longint unsigned];
  logic [7:0] zb [longint unsigned];
  exp_t q[$];
  exp_t zq[$];

  mem_bus_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  mem_bus_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_size(z_req_size), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_error(z_rsp_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Byte-addressed reference memory; sel picks the zero-wait instance's model.
  task automatic model(input bit sel, input logic w, input logic [63:0] a, input logic [1:0] s,
                       input logic [63:0] d, output exp_t e);
    int n;
    logic [7:0] b;
    n = 1 << s;
    e.rdata = '0;
    e.err   = 1'b0;
    if ((a % n) != 0 || (a >> 3) >= DEPTH) begin
      e.err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (w) begin
        if (sel) zb[a + i] = d[8*i +: 8];
        else     mb[a + i] = d[8*i +: 8];
      end else begin
        b = 8'h00;
        if (sel) begin
          if (zb.exists(a + i)) b = zb[a + i];
        end else if (mb.exists(a + i)) begin
          b = mb[a + i];
        end
        e.rdata[8*i +: 8] = b;
      end
    end
  endtask

  task automatic txn(input logic w, input logic [63:0] a, input logic [1:0] s, input logic [63:0] d,
                     input int stall, input string nm);
    exp_t e;
    int n;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = s; req_wdata = d;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL %s accept timeout", nm);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    model(1'b0, w, a, s, d, e);
    q.push_back(e);
    @(negedge clock);
    req_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    checks++;
    if (n != WS + 1) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=%0d", nm, n, WS + 1);
    end
    if (n >= 50) begin
      void'(q.pop_front());
      return;
    end
    for (int i = 0; i < stall; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== q[0].rdata || rsp_error !== q[0].err || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s stall%0d valid=%b rdata=%h err=%b ready=%b exp rdata=%h err=%b",
                 nm, i, rsp_valid, rsp_rdata, rsp_error, req_ready, q[0].rdata, q[0].err);
      end
      @(negedge clock);
    end
    e = q.pop_front();
    checks++;
    if (rsp_rdata !== e.rdata || rsp_error !== e.err) begin
      failures++;
      $display("FAIL %s rsp got rdata=%h err=%b exp rdata=%h err=%b", nm, rsp_rdata, rsp_error, e.rdata, e.err);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s req_ready during resp got=%b exp=0", nm, req_ready);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s post-handshake valid=%b ready=%b exp valid=0 ready=1", nm, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'h0 || rsp_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_ws2 ready=%b valid=%b rdata=%h err=%b exp 1/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_error);
    end
    checks++;
    if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0 || z_rsp_rdata !== 64'h0 || z_rsp_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_ws0 ready=%b valid=%b rdata=%h err=%b exp 1/0/0/0", z_req_ready, z_rsp_valid, z_rsp_rdata, z_rsp_error);
    end
  endtask

  task automatic test_store_load;
    txn(1'b1, 64'h10, 2'b11, 64'h1122334455667788, 0, "store_d_10");
    txn(1'b0, 64'h10, 2'b11, 64'h0, 0, "load_d_10");
  endtask

  task automatic test_byte_lanes;
    txn(1'b1, 64'h13, 2'b00, 64'hFFFF_FFFF_FFFF_FFAB, 0, "store_b_13");
    txn(1'b0, 64'h10, 2'b11, 64'h0, 0, "load_d_10_merged");
    txn(1'b0, 64'h13, 2'b00, 64'h0, 0, "load_b_13");
    txn(1'b0, 64'h12, 2'b01, 64'h0, 0, "load_h_12");
    txn(1'b1, 64'h14, 2'b10, 64'h5555_5555_9ABC_DEF0, 0, "store_w_14");
    txn(1'b0, 64'h10, 2'b11, 64'h0, 0, "load_d_10_word");
  endtask

  task automatic test_errors;
    txn(1'b1, 64'h0, 2'b11, 64'hCAFE_F00D_1234_5678, 0, "store_d_0");
    txn(1'b0, 64'h12, 2'b10, 64'h0, 0, "load_w_misaligned");
    txn(1'b1, 64'h11, 2'b01, 64'hBEEF, 0, "store_h_misaligned");
    txn(1'b1, 64'h8000, 2'b11, 64'hDEAD_DEAD_DEAD_DEAD, 0, "store_d_oor");
    txn(1'b0, 64'h7FF8, 2'b11, 64'h0, 0, "load_d_last_word");
    txn(1'b0, 64'h0, 2'b11, 64'h0, 0, "load_d_0_after_oor");
    txn(1'b0, 64'h10, 2'b11, 64'h0, 0, "load_d_10_after_err");
  endtask

  task automatic test_backpressure;
    txn(1'b0, 64'h10, 2'b11, 64'h0, 5, "backpressure");
  endtask

  task automatic test_reset_mid;
    txn(1'b1, 64'h20, 2'b11, 64'h0102030405060708, 0, "store_d_20");
    txn(1'b0, 64'h20, 2'b11, 64'h0, 0, "load_d_20");
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_size = 2'b11; req_wdata = '1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid in_wait ready=%b valid=%b exp 0/0", req_ready, rsp_valid);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'h0 || rsp_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid outputs ready=%b valid=%b rdata=%h err=%b exp 1/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_error);
    end
    txn(1'b0, 64'h20, 2'b11, 64'h0, 0, "load_d_20_after_reset");
  endtask

  task automatic test_back_to_back;
    logic        w [7]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [63:0] a [7]   = '{64'h0, 64'h8, 64'h0, 64'h9, 64'hC, 64'h5, 64'h8};
    logic [1:0]  s [7]   = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11};
    logic [63:0] d [7]   = '{64'hDEADBEEF01234567, 64'h0F1E2D3C4B5A6978, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    exp_t   e;
    int     n;
    longint last;
    last = 0;
    z_rsp_ready = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 7; i++) begin
      z_req_valid = 1'b1; z_req_write = w[i]; z_req_addr = a[i]; z_req_size = s[i]; z_req_wdata = d[i];
      n = 0;
      while (z_req_ready !== 1'b1 && n < 10) begin @(negedge clock); n++; end
      if (n >= 10) begin
        checks++; failures++;
        $display("FAIL b2b%0d accept timeout", i);
        break;
      end
      @(posedge clock);
      model(1'b1, w[i], a[i], s[i], d[i], e);
      zq.push_back(e);
      @(negedge clock);
      if (i > 0) begin
        checks++;
        if (cyc - last != 2) begin
          failures++;
          $display("FAIL b2b%0d accept_gap got=%0d exp=2", i, cyc - last);
        end
      end
      last = cyc;
      checks++;
      if (z_rsp_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b%0d rsp_valid got=%b exp=1", i, z_rsp_valid);
      end
      e = zq.pop_front();
      checks++;
      if (z_rsp_rdata !== e.rdata || z_rsp_error !== e.err) begin
        failures++;
        $display("FAIL b2b%0d rsp got rdata=%h err=%b exp rdata=%h err=%b", i, z_rsp_rdata, z_rsp_error, e.rdata, e.err);
      end
    end
    z_req_valid = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_size = '0; z_req_wdata = '0; z_rsp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
